acc_rd_arbiter: RTL

- Shares the accelerator's single external-memory read port between three burst requesters: weight loader (id 0), input-map loader (id 1) and partial-sum reload (id 2).
- Grants one burst at a time in round-robin order and forwards the command to memory.
- Steers returned read beats to the granted requester and holds the grant until the last beat.
- Sits between the loaders sequenced by the main controller and the memory interface.

---
 rtl/acc_rd_arbiter_pkg.sv | 35 +++
 rtl/acc_rd_arbiter_if.sv | 50 +++++
 rtl/acc_rd_arbiter_rr_pick.sv | 39 +++
 rtl/acc_rd_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/acc_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// acc_arb_pkg
// Shared definitions for the accelerator read-port arbiter slice:
//   - arb_state_e : arbiter state encoding (IDLE / CMD / DATA)
//   - REQ_*       : fixed requester ids on the arbiter's request vector
//   - DEF_*       : default widths used by the interface and modules
//   - idxWidth()  : width of an index able to address n requesters
// No ports (package).
// ---------------------------------------------------------------------------
package acc_arb_pkg;

    // Default configuration of the arbiter and its bus interface
    localparam int DEF_NREQ   = 3;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LEN_W  = 8;
    localparam int DEF_DATA_W = 64;

    // Requester ids as wired by the main controller
    localparam int REQ_WEIGHT = 0;
    localparam int REQ_IMAP   = 1;
    localparam int REQ_PSUM   = 2;

    // Arbiter states: arbitrate, present command, stream beats
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CMD  = 2'b01,
        DATA = 2'b10
    } arb_state_e;

    // A single requester still needs a one-bit index
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// acc_rd_arbiter_if
// Bundles the requester-side and memory-side signals of the read arbiter.
//   Requester side : req_valid, req_addr, req_len (in to arbiter),
//                    req_ready, rd_valid, rd_data, rd_last (out of arbiter)
//   Memory side    : mem_cmd_valid, mem_cmd_addr, mem_cmd_len (out),
//                    mem_cmd_ready, mem_rd_valid, mem_rd_data (in)
// Modports:
//   slave  - the arbiter's view
//   master - the view of the surrounding loaders/memory model
// req_addr/req_len are flat vectors; slice i belongs to requester i.
// ---------------------------------------------------------------------------
interface acc_rd_arbiter_if
    import acc_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*LEN_W-1:0]  req_len;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic                   rd_last;
    logic                   mem_cmd_valid;
    logic                   mem_cmd_ready;
    logic [ADDR_W-1:0]      mem_cmd_addr;
    logic [LEN_W-1:0]       mem_cmd_len;
    logic                   mem_rd_valid;
    logic [DATA_W-1:0]      mem_rd_data;

    modport slave (
        input  req_valid, req_addr, req_len,
        input  mem_cmd_ready, mem_rd_valid, mem_rd_data,
        output req_ready, rd_valid, rd_data, rd_last,
        output mem_cmd_valid, mem_cmd_addr, mem_cmd_len
    );

    modport master (
        output req_valid, req_addr, req_len,
        output mem_cmd_ready, mem_rd_valid, mem_rd_data,
        input  req_ready, rd_valid, rd_data, rd_last,
        input  mem_cmd_valid, mem_cmd_addr, mem_cmd_len
    );

endinterface

// File: rtl/acc_rd_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_ptr+1, i_ptr+2, ... modulo
// NREQ and returns the first requesting index.
// Ports:
//   i_req    [NREQ]  : request vector
//   i_ptr    [IDX_W] : index granted last (highest priority goes to ptr+1)
//   o_winner [IDX_W] : winning index (0 when nothing requests)
//   o_any            : at least one request is set
// ---------------------------------------------------------------------------
module rr_pick
    import acc_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = idxWidth(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    // Walk the candidates from farthest to nearest so that the nearest
    // requester after the pointer is the last one written and wins.
    always_comb begin
        logic [IDX_W-1:0] w_idx;
        o_winner = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % NREQ);
            if (i_req[w_idx]) begin
                o_winner = w_idx;
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/acc_rd_arbiter.sv
// ---------------------------------------------------------------------------
// acc_rd_arbiter
// Shares the accelerator's single external-memory read port between NREQ
// burst requesters (weight loader, input-map loader, partial-sum reload).
// One burst is granted at a time in round-robin order; the winner's command
// is latched and presented to memory, and returned beats are steered to the
// granted requester until the last beat of the burst.
//
// Ports:
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   bus       : acc_rd_arbiter_if.slave (requester and memory handshakes)
//   busy      : arbiter is in CMD or DATA
//   grant_id  : current or most recently granted requester index
//   err_stray : sticky protocol error flag
//
// Configuration macro ACC_RD_ARB_ERR_EN: when defined, err_stray latches a
// read beat arriving outside DATA or a mem_cmd_ready without mem_cmd_valid.
// When undefined, err_stray is tied low and no checking logic exists.
// ---------------------------------------------------------------------------
module acc_rd_arbiter
    import acc_arb_pkg::*;
#(
    parameter int NREQ   = DEF_NREQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    acc_rd_arbiter_if.slave  bus,
    output logic             busy,
    output logic [2:0]       grant_id,
    output logic             err_stray
);

    localparam int IDX_W = idxWidth(NREQ);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    arb_state_e        r_state;
    logic [IDX_W-1:0]  r_rrPtr;
    logic [IDX_W-1:0]  r_grant;
    logic [ADDR_W-1:0] r_cmdAddr;
    logic [LEN_W-1:0]  r_cmdLen;
    logic [LEN_W-1:0]  r_beatCnt;
    logic              r_cmdValid;
    logic              r_busy;

    logic [IDX_W-1:0]  w_winner;
    logic              w_any;
    logic [ADDR_W-1:0] w_winAddr;
    logic [LEN_W-1:0]  w_winLen;
    logic              w_accept;
    logic              w_beat;
    logic              w_lastBeat;
    logic [NREQ-1:0]   w_grantOneHot;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (bus.req_valid),
        .i_ptr    (r_rrPtr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Select the winner's slice of the flat address/length buses; constant
    // slices per candidate keep the mux free of variable part-selects.
    always_comb begin
        w_winAddr = '0;
        w_winLen  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == IDX_W'(i)) begin
                w_winAddr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_winLen  = bus.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_accept      = (r_state == CMD) && bus.mem_cmd_ready;
    assign w_beat        = (r_state == DATA) && bus.mem_rd_valid;
    assign w_lastBeat    = w_beat && (r_beatCnt == '0);
    assign w_grantOneHot = ONE_HOT0 << r_grant;

    // Accept pulse and beat steering are combinational so the requester sees
    // them in the same cycle as the memory-side event; beats outside DATA
    // never reach a requester.
    assign bus.req_ready     = w_accept ? w_grantOneHot : '0;
    assign bus.rd_valid      = w_beat ? w_grantOneHot : '0;
    assign bus.rd_data       = bus.mem_rd_data;
    assign bus.rd_last       = w_lastBeat;
    assign bus.mem_cmd_valid = r_cmdValid;
    assign bus.mem_cmd_addr  = r_cmdAddr;
    assign bus.mem_cmd_len   = r_cmdLen;
    assign busy              = r_busy;

    // Widen the internal index onto the fixed 3-bit status port
    always_comb begin
        grant_id              = '0;
        grant_id[IDX_W-1:0]   = r_grant;
    end

    // Arbiter FSM. IDLE latches the round-robin winner's command, CMD holds it
    // until memory accepts, DATA counts beats down from len so len=0 is a
    // single beat and the all-ones len gives 2^LEN_W beats without wrapping.
    // The pointer only moves when a burst completes, which is what produces
    // the 0,1,2,... rotation under full load. Reset drops any open burst.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rrPtr    <= IDX_W'(NREQ - 1);
            r_grant    <= '0;
            r_cmdAddr  <= '0;
            r_cmdLen   <= '0;
            r_beatCnt  <= '0;
            r_cmdValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cmdAddr  <= w_winAddr;
                        r_cmdLen   <= w_winLen;
                        r_grant    <= w_winner;
                        r_cmdValid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= CMD;
                    end
                end
                CMD: begin
                    if (bus.mem_cmd_ready) begin
                        r_cmdValid <= 1'b0;
                        r_beatCnt  <= r_cmdLen;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (bus.mem_rd_valid) begin
                        if (r_beatCnt == '0) begin
                            r_rrPtr <= r_grant;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_beatCnt <= r_beatCnt - LEN_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ACC_RD_ARB_ERR_EN
    logic r_errStray;

    // Sticky protocol monitor: a read beat with no burst streaming, or a
    // command accept with no command offered, flags the memory side as
    // misbehaving until the next reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_errStray <= 1'b0;
        end else if ((bus.mem_rd_valid && (r_state != DATA)) ||
                     (bus.mem_cmd_ready && !r_cmdValid)) begin
            r_errStray <= 1'b1;
        end
    end

    assign err_stray = r_errStray;
`else
    assign err_stray = 1'b0;
`endif

endmodule
